// File: rtl/cpu_pkg.sv
// Shared CPU constants for the write-back / register-file slice.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  // Architectural register 0 is hardwired to zero.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    MEMTOREG_ALU  = 1'b0,
    MEMTOREG_LOAD = 1'b1
  } memtoreg_e;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bus: write-back controls/data in, ID read ports and perf outputs out.
interface wb_regfile_if #(
  parameter int DATA_W = cpu_pkg::DATA_W_DEF,
  parameter int ADDR_W = cpu_pkg::ADDR_W_DEF,
  parameter int CNT_W  = cpu_pkg::CNT_W_DEF
);

  logic              stall_i;
  logic              RegWrite_i;
  logic              MemtoReg_i;
  logic [DATA_W-1:0] mux0_i;
  logic [DATA_W-1:0] mux1_i;
  logic [ADDR_W-1:0] WriteBackPath_i;
  logic [ADDR_W-1:0] RS1addr_i;
  logic [ADDR_W-1:0] RS2addr_i;
  logic [DATA_W-1:0] RS1data_o;
  logic [DATA_W-1:0] RS2data_o;
  logic [DATA_W-1:0] wb_data_o;
  logic              wb_valid_o;
  logic [CNT_W-1:0]  retire_cnt_o;

  modport master (
    output stall_i, RegWrite_i, MemtoReg_i, mux0_i, mux1_i,
           WriteBackPath_i, RS1addr_i, RS2addr_i,
    input  RS1data_o, RS2data_o, wb_data_o, wb_valid_o, retire_cnt_o
  );

  modport slave (
    input  stall_i, RegWrite_i, MemtoReg_i, mux0_i, mux1_i,
           WriteBackPath_i, RS1addr_i, RS2addr_i,
    output RS1data_o, RS2data_o, wb_data_o, wb_valid_o, retire_cnt_o
  );

endinterface

// File: rtl/wb_regfile_core.sv
// Register storage: async-reset array, one write port, two combinational read ports, no bypass.
module wb_regfile_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the WB value, qualifies the commit, bypasses it to the ID read
// ports and counts retired register writes.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  wb_regfile_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic [DATA_W-1:0] core_rd1;
  logic [DATA_W-1:0] core_rd2;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [CNT_W-1:0]  retire_cnt_d;

  always_comb begin
    wb_data = (memtoreg_e'(bus.MemtoReg_i) == MEMTOREG_LOAD) ? bus.mux1_i : bus.mux0_i;
    // A stalled MEM/WB entry is held, so it must only commit on the cycle stall drops.
    wb_valid = bus.RegWrite_i & ~bus.stall_i & (bus.WriteBackPath_i != ZERO_IDX);
  end

  wb_regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (wb_valid),
    .waddr_i  (bus.WriteBackPath_i),
    .wdata_i  (wb_data),
    .raddr1_i (bus.RS1addr_i),
    .raddr2_i (bus.RS2addr_i),
    .rdata1_o (core_rd1),
    .rdata2_o (core_rd2)
  );

  // Same-cycle write-through so ID sees the value being committed this edge.
  always_comb begin
    rs1_data = core_rd1;
    if (bus.RS1addr_i == ZERO_IDX) begin
      rs1_data = '0;
    end else if (wb_valid && (bus.RS1addr_i == bus.WriteBackPath_i)) begin
      rs1_data = wb_data;
    end

    rs2_data = core_rd2;
    if (bus.RS2addr_i == ZERO_IDX) begin
      rs2_data = '0;
    end else if (wb_valid && (bus.RS2addr_i == bus.WriteBackPath_i)) begin
      rs2_data = wb_data;
    end
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (wb_valid) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.wb_data_o    = wb_data;
  assign bus.wb_valid_o   = wb_valid;
  assign bus.RS1data_o    = rs1_data;
  assign bus.RS2data_o    = rs2_data;
  assign bus.retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, WB select, bypass, r0, stall and counter wrap.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) ifc ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  ifc_s ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (ifc.slave)
  );

  // Narrow-counter build sees the same stimulus as the main instance.
  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_s (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (ifc_s.slave)
  );

  assign ifc_s.stall_i         = ifc.stall_i;
  assign ifc_s.RegWrite_i      = ifc.RegWrite_i;
  assign ifc_s.MemtoReg_i      = ifc.MemtoReg_i;
  assign ifc_s.mux0_i          = ifc.mux0_i;
  assign ifc_s.mux1_i          = ifc.mux1_i;
  assign ifc_s.WriteBackPath_i = ifc.WriteBackPath_i;
  assign ifc_s.RS1addr_i       = ifc.RS1addr_i;
  assign ifc_s.RS2addr_i       = ifc.RS2addr_i;

  task automatic drive(input logic we, input logic mts, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [4:0] dest,
                       input logic [4:0] a1, input logic [4:0] a2, input logic stall);
    ifc.RegWrite_i      = we;
    ifc.MemtoReg_i      = mts;
    ifc.mux0_i          = d0;
    ifc.mux1_i          = d1;
    ifc.WriteBackPath_i = dest;
    ifc.RS1addr_i       = a1;
    ifc.RS2addr_i       = a2;
    ifc.stall_i         = stall;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ifc.RS1data_o !== 32'h0) begin errs++; $display("FAIL reset_r5 got=%h exp=%h", ifc.RS1data_o, 32'h0); end
    checks++; if (ifc.retire_cnt_o !== 32'd0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", ifc.retire_cnt_o); end
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 5'd5, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, 1'b0);
    #1;
    checks++; if (ifc.RS1data_o !== 32'hDEADBEEF) begin errs++; $display("FAIL pre_reset_r5 got=%h exp=%h", ifc.RS1data_o, 32'hDEADBEEF); end
    checks++; if (ifc.retire_cnt_o !== 32'd1) begin errs++; $display("FAIL pre_reset_cnt got=%0d exp=1", ifc.retire_cnt_o); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.RS1data_o !== 32'h0) begin errs++; $display("FAIL async_reset_r5 got=%h exp=%h", ifc.RS1data_o, 32'h0); end
    checks++; if (ifc.retire_cnt_o !== 32'd0) begin errs++; $display("FAIL async_reset_cnt got=%0d exp=0", ifc.retire_cnt_o); end
    // A write presented while reset is held must be dropped.
    drive(1'b1, 1'b0, 32'h66, 32'h0, 5'd6, 5'd6, 5'd6, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd6, 1'b0);
    #1;
    checks++; if (ifc.RS1data_o !== 32'h0) begin errs++; $display("FAIL reset_abort_r6 got=%h exp=%h", ifc.RS1data_o, 32'h0); end
    checks++; if (ifc.retire_cnt_o !== 32'd0) begin errs++; $display("FAIL reset_abort_cnt got=%0d exp=0", ifc.retire_cnt_o); end
  endtask

  task automatic test_select();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h11, 32'h22, 5'd3, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (ifc.wb_data_o !== 32'h11) begin errs++; $display("FAIL sel_alu got=%h exp=%h", ifc.wb_data_o, 32'h11); end
    checks++; if (ifc.wb_valid_o !== 1'b1) begin errs++; $display("FAIL sel_alu_valid got=%b exp=1", ifc.wb_valid_o); end
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h11, 32'h22, 5'd4, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (ifc.wb_data_o !== 32'h22) begin errs++; $display("FAIL sel_load got=%h exp=%h", ifc.wb_data_o, 32'h22); end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4, 1'b0);
    #1;
    checks++; if (ifc.RS1data_o !== 32'h11) begin errs++; $display("FAIL sel_r3 got=%h exp=%h", ifc.RS1data_o, 32'h11); end
    checks++; if (ifc.RS2data_o !== 32'h22) begin errs++; $display("FAIL sel_r4 got=%h exp=%h", ifc.RS2data_o, 32'h22); end
    checks++; if (ifc.retire_cnt_o !== 32'd2) begin errs++; $display("FAIL sel_cnt got=%0d exp=2", ifc.retire_cnt_o); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 5'd7, 5'd7, 5'd7, 1'b0);
    #1;
    checks++; if (ifc.RS1data_o !== 32'hCAFEF00D) begin errs++; $display("FAIL byp_rs1 got=%h exp=%h", ifc.RS1data_o, 32'hCAFEF00D); end
    checks++; if (ifc.RS2data_o !== 32'hCAFEF00D) begin errs++; $display("FAIL byp_rs2 got=%h exp=%h", ifc.RS2data_o, 32'hCAFEF00D); end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7, 1'b0);
    #1;
    checks++; if (ifc.RS1data_o !== 32'hCAFEF00D) begin errs++; $display("FAIL byp_post_rs1 got=%h exp=%h", ifc.RS1data_o, 32'hCAFEF00D); end
    checks++; if (ifc.RS2data_o !== 32'hCAFEF00D) begin errs++; $display("FAIL byp_post_rs2 got=%h exp=%h", ifc.RS2data_o, 32'hCAFEF00D); end
    // Overwrite r3: port 1 must see the new value, port 2 (r4) is untouched.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h33, 32'h0, 5'd3, 5'd3, 5'd4, 1'b0);
    #1;
    checks++; if (ifc.RS1data_o !== 32'h33) begin errs++; $display("FAIL byp_over_r3 got=%h exp=%h", ifc.RS1data_o, 32'h33); end
    checks++; if (ifc.RS2data_o !== 32'h22) begin errs++; $display("FAIL byp_other_r4 got=%h exp=%h", ifc.RS2data_o, 32'h22); end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7, 1'b0);
    #1;
    checks++; if (ifc.RS1data_o !== 32'h33) begin errs++; $display("FAIL byp_stored_r3 got=%h exp=%h", ifc.RS1data_o, 32'h33); end
    checks++; if (ifc.retire_cnt_o !== 32'd4) begin errs++; $display("FAIL byp_cnt got=%0d exp=4", ifc.retire_cnt_o); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (ifc.wb_valid_o !== 1'b0) begin errs++; $display("FAIL zero_valid got=%b exp=0", ifc.wb_valid_o); end
    checks++; if (ifc.wb_data_o !== 32'hFFFFFFFF) begin errs++; $display("FAIL zero_wbdata got=%h exp=%h", ifc.wb_data_o, 32'hFFFFFFFF); end
    checks++; if (ifc.RS1data_o !== 32'h0) begin errs++; $display("FAIL zero_byp_rs1 got=%h exp=0", ifc.RS1data_o); end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (ifc.RS2data_o !== 32'h0) begin errs++; $display("FAIL zero_r0 got=%h exp=0", ifc.RS2data_o); end
    checks++; if (ifc.retire_cnt_o !== 32'd4) begin errs++; $display("FAIL zero_cnt got=%0d exp=4", ifc.retire_cnt_o); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h55, 32'h0, 5'd9, 5'd9, 5'd9, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (ifc.wb_valid_o !== 1'b0) begin errs++; $display("FAIL stall_valid_c%0d got=%b exp=0", c, ifc.wb_valid_o); end
      checks++; if (ifc.RS1data_o !== 32'h0) begin errs++; $display("FAIL stall_r9_c%0d got=%h exp=0", c, ifc.RS1data_o); end
      @(negedge clk);
    end
    checks++; if (ifc.retire_cnt_o !== 32'd4) begin errs++; $display("FAIL stall_cnt got=%0d exp=4", ifc.retire_cnt_o); end
    ifc.stall_i = 1'b0;
    #1;
    checks++; if (ifc.RS2data_o !== 32'h55) begin errs++; $display("FAIL stall_release_byp got=%h exp=%h", ifc.RS2data_o, 32'h55); end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9, 1'b0);
    #1;
    checks++; if (ifc.RS1data_o !== 32'h55) begin errs++; $display("FAIL stall_r9 got=%h exp=%h", ifc.RS1data_o, 32'h55); end
    checks++; if (ifc.retire_cnt_o !== 32'd5) begin errs++; $display("FAIL stall_cnt_once got=%0d exp=5", ifc.retire_cnt_o); end
    @(negedge clk);
    checks++; if (ifc.retire_cnt_o !== 32'd5) begin errs++; $display("FAIL stall_cnt_hold got=%0d exp=5", ifc.retire_cnt_o); end
  endtask

  task automatic test_back_to_back_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (ifc_s.retire_cnt_o !== 4'd0) begin errs++; $display("FAIL wrap_reset got=%0d exp=0", ifc_s.retire_cnt_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 32'(i) + 32'h100, 32'h0, 5'(i + 1), 5'd0, 5'd0, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd1, 1'b0);
    #1;
    checks++; if (ifc_s.retire_cnt_o !== 4'd1) begin errs++; $display("FAIL wrap_cnt4 got=%0d exp=1", ifc_s.retire_cnt_o); end
    checks++; if (ifc.retire_cnt_o !== 32'd17) begin errs++; $display("FAIL wrap_cnt32 got=%0d exp=17", ifc.retire_cnt_o); end
    checks++; if (ifc.RS1data_o !== 32'h110) begin errs++; $display("FAIL b2b_r17 got=%h exp=%h", ifc.RS1data_o, 32'h110); end
    checks++; if (ifc.RS2data_o !== 32'h100) begin errs++; $display("FAIL b2b_r1 got=%h exp=%h", ifc.RS2data_o, 32'h100); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_bypass();
    test_zero_reg();
    test_stall();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
